// File: rtl/seq_divider12.sv
// seq_divider12 -- iterative restoring divider, one quotient bit per clock.
//
// This is the divide path of the arithmetic unit and sits beside the Vedic
// multiplier. It works on unsigned WIDTH-bit operands. Each RUN step makes a
// trial subtraction (rem + ~divisor + 1) on a WIDTH+1-bit ripple chain of
// full-adder cells. The carry out of the chain is the new quotient bit. When
// the carry is 0, the subtraction borrowed and the shifted remainder is kept
// (restoring division).
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request, sampled only in IDLE or DONE
//   dividend     in   WIDTH  numerator, captured on the accepted start edge
//   divisor      in   WIDTH  denominator, captured on the accepted start edge
//   busy         out  1      high while RUN is iterating
//   done         out  1      one-cycle pulse, results valid from here on
//   quotient     out  WIDTH  floor(dividend/divisor), or all ones on /0
//   remainder    out  WIDTH  dividend mod divisor, or the dividend on /0
//   div_by_zero  out  1      set with done when the captured divisor was 0
module seq_divider12 #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  // The trial subtraction is built from these signals.
  // w_a is {rem,q} shifted left by one, keeping only the top WIDTH+1 bits.
  // w_b is the complement of the zero-extended divisor.
  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [WIDTH+1:0] w_carry;
  logic [WIDTH-1:0] w_trial;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_a        = {r_rem, r_q[WIDTH-1]};
  assign w_b        = ~{1'b0, r_divisor};
  assign w_carry[0] = 1'b1;

  // This is a ripple chain of full-adder cells. The top cell only produces
  // the carry. Its sum bit is never needed, because a non-borrowing trial is
  // always smaller than the divisor.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign w_carry[i+1] = (w_a[i] & w_b[i]) | (w_carry[i] & (w_a[i] ^ w_b[i]));
    if (i < WIDTH) begin : g_sum
      assign w_trial[i] = w_a[i] ^ w_b[i] ^ w_carry[i];
    end
  end

  // A carry out of the top cell means the subtraction did not borrow.
  assign w_no_borrow = w_carry[WIDTH+1];
  // On a borrow, the shifted remainder fits in WIDTH bits: it is smaller than the divisor.
  assign w_rem_next  = w_no_borrow ? w_trial : w_a[WIDTH-1:0];
  assign w_q_next    = {r_q[WIDTH-2:0], w_no_borrow};

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_next_state = (divisor == '0) ? S_DONE : S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem         <= '0;
      r_q           <= '0;
      r_cnt         <= '0;
      r_divisor     <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_divisor <= divisor;
      if (divisor == '0) begin
        // For divide-by-zero, the result is delivered directly on the start edge.
        r_quotient    <= '1;
        r_remainder   <= dividend;
        r_div_by_zero <= 1'b1;
      end else begin
        r_rem <= '0;
        r_q   <= dividend;
        r_cnt <= CNT_LOAD;
      end
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt - CNT_W'(1);
      // The visible outputs change only on the final step, which enters DONE.
      if (r_cnt == '0) begin
        r_quotient    <= w_q_next;
        r_remainder   <= w_rem_next;
        r_div_by_zero <= 1'b0;
      end
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
